// File: rtl/cdc_gray_ptr_rx_if.sv
// Bundle between a CDC FIFO pointer block and its gray-pointer receiver.
// The ptrErr signal exists only when CDC_GRAY_RX_CHECK_EN is defined.
interface cdc_gray_ptr_rx_if #(
   parameter int n_bits = 4
);
   logic [n_bits-1:0] remoteGray;
   logic [n_bits-1:0] localBin;
   logic [n_bits-1:0] remoteBin;
   logic [n_bits-1:0] level;
   logic              empty;
   logic              full;
   logic              remoteZero;
`ifdef CDC_GRAY_RX_CHECK_EN
   logic              ptrErr;

   modport master (
      output remoteGray, localBin,
      input  remoteBin, level, empty, full, remoteZero, ptrErr
   );
   modport slave (
      input  remoteGray, localBin,
      output remoteBin, level, empty, full, remoteZero, ptrErr
   );
`else
   modport master (
      output remoteGray, localBin,
      input  remoteBin, level, empty, full, remoteZero
   );
   modport slave (
      input  remoteGray, localBin,
      output remoteBin, level, empty, full, remoteZero
   );
`endif
endinterface

// File: rtl/cdc_gray_ptr_rx.sv
// Receive side of a gray pointer crossing: synchronize, decode, and derive level/empty/full.
// Optional pointer-integrity monitor (sticky ptrErr) enabled by defining CDC_GRAY_RX_CHECK_EN.
module cdc_gray_ptr_rx #(
   parameter int                n_bits        = 4,
   parameter int                sync_stages   = 2,   // meaningful range 2..4
   parameter logic [n_bits-1:0] gray_rstValue = '0
) (
   input logic              clk,
   input logic              sysRst,
   cdc_gray_ptr_rx_if.slave rxBus
);

   function automatic logic [n_bits-1:0] gray2bin(input logic [n_bits-1:0] g);
      logic [n_bits-1:0] b;
      b[n_bits-1] = g[n_bits-1];
      for (int i = n_bits - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   localparam logic [n_bits-1:0] binRstValue = gray2bin(gray_rstValue);
   localparam logic [n_bits-1:0] halfDepth   = {1'b1, {(n_bits-1){1'b0}}};

   logic [n_bits-1:0] syncReg [sync_stages];
   logic [n_bits-1:0] syncLast;
   logic [n_bits-1:0] decBin;
   logic [n_bits-1:0] remoteBinReg;
   logic [n_bits-1:0] levelReg;
   logic              emptyReg;
   logic              fullReg;
   logic [n_bits-1:0] lvlC;

   // Plain flop chain: nothing combinational between stages so metastability can settle.
   always_ff @(posedge clk) begin
      if (sysRst) begin
         for (int i = 0; i < sync_stages; i++) begin
            syncReg[i] <= gray_rstValue;
         end
      end else begin
         syncReg[0] <= rxBus.remoteGray;
         for (int i = 1; i < sync_stages; i++) begin
            syncReg[i] <= syncReg[i-1];
         end
      end
   end

   assign syncLast = syncReg[sync_stages-1];

   // Each binary bit is the XOR of all gray bits at or above it.
   genvar gi;
   generate
      for (gi = 0; gi < n_bits; gi++) begin : genDecode
         assign decBin[gi] = ^syncLast[n_bits-1:gi];
      end
   endgenerate

   // Modulo subtraction handles pointer wrap without any special casing.
   assign lvlC = remoteBinReg - rxBus.localBin;

   always_ff @(posedge clk) begin
      if (sysRst) begin
         remoteBinReg <= binRstValue;
         levelReg     <= '0;
         emptyReg     <= 1'b1;
         fullReg      <= 1'b0;
      end else begin
         remoteBinReg <= decBin;
         levelReg     <= lvlC;
         emptyReg     <= (lvlC == '0);
         fullReg      <= (lvlC == halfDepth);
      end
   end

   assign rxBus.remoteBin  = remoteBinReg;
   assign rxBus.level      = levelReg;
   assign rxBus.empty      = emptyReg;
   assign rxBus.full       = fullReg;
   assign rxBus.remoteZero = (remoteBinReg == '0);

`ifdef CDC_GRAY_RX_CHECK_EN
   logic [n_bits-1:0] prevReg;
   logic [n_bits-1:0] hopBits;
   logic              multiHop;
   logic              lvlIllegal;
   logic              ptrErrReg;

   // v & (v-1) clears the lowest set bit; non-zero means two or more bits flipped.
   assign hopBits    = prevReg ^ syncLast;
   assign multiHop   = (hopBits & (hopBits - n_bits'(1))) != '0;
   assign lvlIllegal = (lvlC > halfDepth);

   always_ff @(posedge clk) begin
      if (sysRst) begin
         prevReg   <= gray_rstValue;
         ptrErrReg <= 1'b0;
      end else begin
         prevReg <= syncLast;
         if (multiHop || lvlIllegal) begin
            ptrErrReg <= 1'b1;
         end
      end
   end

   assign rxBus.ptrErr = ptrErrReg;
`endif

endmodule
